// File: rtl/regfile_storage.sv
// rtl/regfile_storage.sv - 32 x 64-bit register file storage, write decoder and hardwired-zero XZR
module regfile_storage #(
   parameter int WIDTH    = 64,
   parameter int NREGS    = 32,
   parameter int ZERO_REG = 31
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     RegWrite,
   input  logic [$clog2(NREGS)-1:0] WriteRegister,
   input  logic [WIDTH-1:0]         WriteData,
   output logic [WIDTH-1:0]         dataFromReg [NREGS-1:0],
   output logic [NREGS-1:0]         writeDecode
);

   localparam int AW = $clog2(NREGS);

   genvar gi, gb;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_reg
         if (gi == ZERO_REG) begin : g_zero
            // XZR owns no flops; writes aimed at it simply never decode.
            assign writeDecode[gi] = 1'b0;
            assign dataFromReg[gi] = '0;
         end else begin : g_row
            logic             w_en;
            logic [WIDTH-1:0] w_d;
            logic [WIDTH-1:0] w_q;

            assign w_en            = RegWrite & (WriteRegister == AW'(gi));
            assign writeDecode[gi] = w_en;

            for (gb = 0; gb < WIDTH; gb++) begin : g_bit
               logic r_q;

               // Enable is a feedback mux in front of a plain sync-reset D flop.
               assign w_d[gb] = w_en ? WriteData[gb] : r_q;

               always_ff @(posedge clk) begin
                  if (reset) begin
                     r_q <= 1'b0;
                  end else begin
                     r_q <= w_d[gb];
                  end
               end

               assign w_q[gb] = r_q;
            end

            assign dataFromReg[gi] = w_q;
         end
      end
   endgenerate

endmodule

// File: doc/regfile_storage.md
Name: regfile_storage

Overview:
- Storage half of the single-cycle CPU register file: 32 x 64-bit architectural registers, a 5-to-32 write decoder and per-register write enables.
- Drives the full register array, unregistered, to the two downstream 64-bit 32:1 read multiplexers (ReadData1/ReadData2 ports) every cycle.
- Register 31 (XZR) is hardwired to zero.
- Writes commit on the rising clock edge; reads of the array are purely combinational from flop outputs.

Parameters:
- WIDTH, 64, data width of each register.
- NREGS, 32, number of registers; fixed at 32 (5-bit address).
- ZERO_REG, 31, index of hardwired-zero register; its writes are discarded.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears all registers
- RegWrite  input  1  write enable for this cycle
- WriteRegister  input  5  destination register index
- WriteData  input  64  value written to WriteRegister
- dataFromReg  output  32 x 64 (unpacked [31:0], each [63:0])  current contents of every register, to read muxes
- writeDecode  output  32  one-hot decoded write enable for this cycle (combinational; debug/verification visibility)

Behaviour:
- Reset: on rising clk with reset=1, every dataFromReg[i] <= 64'h0. Reset overrides RegWrite in the same cycle; the write is dropped.
- Decoder: writeDecode[i] = RegWrite & (WriteRegister == i) & (i != ZERO_REG). Exactly one bit is high when RegWrite=1 and WriteRegister != 31; all zero otherwise. Combinational, no latency.
- Write: on rising clk with reset=0, each register i with writeDecode[i]=1 loads WriteData. All other registers hold (D-flop with enable feedback mux per bit).
- Latency: new value is visible on dataFromReg exactly 1 clk edge after the write cycle. No internal read-during-write bypass: in the write cycle, the downstream read mux sees the old value.
- Zero register: dataFromReg[31] is tied to 64'h0 at all times, including during and after reset, and regardless of any write to index 31. It has no flops.
- Back-to-back writes to the same register on consecutive cycles: each edge commits that cycle's WriteData; last write wins.
- RegWrite=0: no register changes, irrespective of WriteRegister/WriteData, including X/garbage on those inputs.
- Reset asserted mid-operation, for example between two writes: all registers read 0 after that edge. The first write after reset deasserts commits normally.
- Power-up before the first reset: contents are undefined, except dataFromReg[31]=0. The bench must apply reset before checking.
- Timing: the write path is decoder, enable mux, then flop D input, within one cycle. dataFromReg is driven directly from flop Q, with no logic between Q and the port.
- Structural build: one generated 64-bit enabled-DFF row per register 0..30. Every storage element uses the team's D flip-flop primitive with synchronous reset.

Test Plan:
- Reset clear: load regs 0..30 with nonzero values, then assert reset for 1 cycle -> all dataFromReg[0..31] = 64'h0 on the next edge.
- Walk write: for i=0..30, write WriteData = i*64'h0101_0101_0101_0101 with RegWrite=1. Then dataFromReg[i] equals that value 1 edge later, and all other registers are unchanged. writeDecode = (1<<i) during each write.
- XZR: RegWrite=1, WriteRegister=31, WriteData=64'hDEAD_BEEF_CAFE_F00D -> dataFromReg[31] stays 0 and writeDecode = 0. No other register changes.
- Write disabled: set reg 5 = 64'h1234, then RegWrite=0, WriteRegister=5, WriteData=64'hFFFF_FFFF_FFFF_FFFF for 3 cycles -> reg 5 stays 64'h1234.
- Same-cycle reset+write: reset=1, RegWrite=1, WriteRegister=7, WriteData=64'hAA -> reg 7 = 0 after the edge. Next cycle, the same write with reset=0 -> reg 7 = 64'hAA.
- Latency/back-to-back: write reg 3 = 64'h11, then 64'h22 on consecutive cycles -> dataFromReg[3] reads 64'h11 after edge 1 and 64'h22 after edge 2. During the write cycle itself, the old value is still visible.
